// File: rtl/cnn_pe_pkg.sv
// Shared PE definitions: scratchpad default geometry and drain FSM states.
// Used by the PSUM drain stage and the PE scratchpads.
package cnn_pe_pkg;

    localparam int PSUM_ADDR_LEN = 4;
    localparam int PSUM_DEPTH    = 16;
    localparam int PSUM_WIDTH    = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        FLUSH = 2'd2,
        ZERO  = 2'd3
    } drain_state_t;

endpackage

// File: rtl/wrap_counter.sv
// Loadable address counter that wraps from DEPTH-1 back to 0,
// so scratchpads whose depth is not a power of two are walked correctly.
module wrap_counter #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             inc,
    output logic [WIDTH-1:0] value
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(DEPTH - 1);
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            value <= '0;
        end else if (load) begin
            value <= load_val;
        end else if (inc) begin
            value <= (value == LAST) ? '0 : value + ONE;
        end
    end

endmodule

// File: rtl/psum_drain.sv
// PSUM scratch drain: walks a wrapped address window and streams words out
// over valid/ready. Optional ReLU on the output via PSUM_DRAIN_RELU_EN.
module psum_drain
    import cnn_pe_pkg::*;
#(
    parameter int ADDR_LEN      = PSUM_ADDR_LEN,
    parameter int SCRATCH_DEPTH = PSUM_DEPTH,
    parameter int SCRATCH_WIDTH = PSUM_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [ADDR_LEN-1:0]      base,
    input  logic [ADDR_LEN:0]        count,
    output logic [ADDR_LEN-1:0]      psum_raddr,
    input  logic [SCRATCH_WIDTH-1:0] psum_rdata,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [SCRATCH_WIDTH-1:0] out_data,
    output logic                     out_last,
    output logic                     busy,
    output logic                     done
);

    localparam logic [ADDR_LEN:0] DEPTH_C = (ADDR_LEN + 1)'(SCRATCH_DEPTH);
    localparam logic [ADDR_LEN:0] ONE     = (ADDR_LEN + 1)'(1);

    drain_state_t state;

    logic [ADDR_LEN:0]        remaining;
    logic [ADDR_LEN-1:0]      rd_ptr;
    logic [ADDR_LEN-1:0]      base_eff;
    logic [ADDR_LEN:0]        count_eff;
    logic [SCRATCH_WIDTH-1:0] word;
    logic                     ld;
    logic                     go;
    logic                     ptr_inc;
    logic                     is_last;

    // Out-of-range window parameters are folded back into the scratchpad.
    always_comb begin
        base_eff  = ({1'b0, base} >= DEPTH_C) ? '0 : base;
        count_eff = (count > DEPTH_C) ? DEPTH_C : count;
    end

`ifdef PSUM_DRAIN_RELU_EN
    always_comb begin
        word = psum_rdata[SCRATCH_WIDTH-1] ? '0 : psum_rdata;
    end
`else
    always_comb begin
        word = psum_rdata;
    end
`endif

    assign ld      = ~out_valid | out_ready;
    assign go      = (state == IDLE) & start & (count != '0);
    assign ptr_inc = (state == DRAIN) & ld;
    assign is_last = (remaining == ONE);
    assign busy    = (state == DRAIN) | (state == FLUSH);

    assign psum_raddr = busy ? rd_ptr : '0;

    wrap_counter #(
        .WIDTH (ADDR_LEN),
        .DEPTH (SCRATCH_DEPTH)
    ) u_rd_ptr (
        .clk      (clk),
        .rst      (rst),
        .load     (go),
        .load_val (base_eff),
        .inc      (ptr_inc),
        .value    (rd_ptr)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            remaining <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        if (count == '0) begin
                            state <= ZERO;
                        end else begin
                            remaining <= count_eff;
                            state     <= DRAIN;
                        end
                    end
                end
                ZERO: begin
                    done  <= 1'b1;
                    state <= IDLE;
                end
                // Load whenever the output slot is empty or being taken.
                DRAIN: begin
                    if (ld) begin
                        out_data  <= word;
                        out_valid <= 1'b1;
                        out_last  <= is_last;
                        remaining <= remaining - ONE;
                        if (is_last) begin
                            state <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        done      <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_psum_drain.sv
// Directed bench for psum_drain: 16-deep and 12-deep instances,
// expected streams hand-computed from the scratch contents.
module tb_psum_drain;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start16;
    logic        start12;
    logic [3:0]  base;
    logic [4:0]  count;
    logic        out_ready;
    logic        sel;

    logic [3:0]  raddr16, raddr12;
    logic [15:0] rdata16, rdata12;
    logic [15:0] data16, data12;
    logic        v16, v12, l16, l12, b16, b12, d16, d12;

    logic [15:0] mem16 [16];
    logic [15:0] mem12 [12];

    assign rdata16 = mem16[raddr16];
    assign rdata12 = (raddr12 < 4'd12) ? mem12[raddr12] : 16'hdead;

    logic [15:0] data;
    logic        vld, last, busy, done;
    logic [3:0]  raddr;

    assign data  = sel ? data12 : data16;
    assign vld   = sel ? v12 : v16;
    assign last  = sel ? l12 : l16;
    assign busy  = sel ? b12 : b16;
    assign done  = sel ? d12 : d16;
    assign raddr = sel ? raddr12 : raddr16;

    psum_drain u_dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start16),
        .base       (base),
        .count      (count),
        .psum_raddr (raddr16),
        .psum_rdata (rdata16),
        .out_valid  (v16),
        .out_ready  (out_ready),
        .out_data   (data16),
        .out_last   (l16),
        .busy       (b16),
        .done       (d16)
    );

    psum_drain #(
        .ADDR_LEN      (4),
        .SCRATCH_DEPTH (12),
        .SCRATCH_WIDTH (16)
    ) u_dut12 (
        .clk        (clk),
        .rst        (rst),
        .start      (start12),
        .base       (base),
        .count      (count),
        .psum_raddr (raddr12),
        .psum_rdata (rdata12),
        .out_valid  (v12),
        .out_ready  (out_ready),
        .out_data   (data12),
        .out_last   (l12),
        .busy       (b12),
        .done       (d12)
    );

    int n_cmp = 0;
    int n_err = 0;
    int exp_q [$];

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_start(input logic v);
        start16 = v & ~sel;
        start12 = v & sel;
    endtask

    // rmode 0: ready always high; 1: ready pattern 1,0,0 repeating.
    // again >= 0: issue a second start (count 3) on that loop cycle.
    task automatic drain(input logic [3:0] b, input logic [4:0] c,
                         input int rmode, input int again,
                         input string tag);
        int          n_acc;
        int          n_done;
        logic        held;
        logic [15:0] hold;
        n_acc  = 0;
        n_done = 0;
        held   = 1'b0;
        hold   = '0;
        base   = b;
        count  = c;
        out_ready = 1'b1;
        set_start(1'b1);
        tick();
        set_start(1'b0);
        for (int cyc = 0; cyc < 200 && n_done == 0; cyc++) begin
            out_ready = (rmode == 0) ? 1'b1 : ((cyc % 3) == 0);
            if (cyc == again) begin
                base  = 4'd0;
                count = 5'd3;
                set_start(1'b1);
            end else begin
                set_start(1'b0);
            end
            if (held) begin
                check({tag, "_hold_data"}, int'(data), int'(hold));
                check({tag, "_hold_vld"}, int'(vld), 1);
            end
            if (vld && out_ready) begin
                if (n_acc < exp_q.size()) begin
                    check({tag, "_data"}, int'($signed(data)), exp_q[n_acc]);
                end
                check({tag, "_last"}, int'(last),
                      int'(n_acc == exp_q.size() - 1));
                n_acc++;
            end
            held = vld & ~out_ready;
            hold = data;
            tick();
            if (done) n_done++;
        end
        set_start(1'b0);
        out_ready = 1'b1;
        check({tag, "_accepts"}, n_acc, exp_q.size());
        check({tag, "_done"}, n_done, 1);
        tick();
        check({tag, "_done_pulse"}, int'(done), 0);
        check({tag, "_idle"}, int'(busy), 0);
    endtask

    initial begin
        rst       = 1'b0;
        sel       = 1'b0;
        start16   = 1'b0;
        start12   = 1'b0;
        base      = '0;
        count     = '0;
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) mem16[i] = 16'(i + 1);
        for (int i = 0; i < 12; i++) mem12[i] = 16'(100 + i);

        tick();
        tick();
        check("rst_valid", int'(vld), 0);
        check("rst_data", int'(data), 0);
        check("rst_last", int'(last), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_raddr", int'(raddr), 0);
        rst = 1'b1;
        tick();

        // Cycle-exact drain of 4 words with ready held high.
        base  = 4'd0;
        count = 5'd4;
        set_start(1'b1);
        tick();
        set_start(1'b0);
        check("e0_busy", int'(busy), 1);
        check("e0_valid", int'(vld), 0);
        check("e0_raddr", int'(raddr), 0);
        for (int k = 1; k <= 4; k++) begin
            tick();
            check("ek_valid", int'(vld), 1);
            check("ek_data", int'(data), k);
            check("ek_last", int'(last), int'(k == 4));
            check("ek_done", int'(done), 0);
            if (k < 4) check("ek_raddr", int'(raddr), k);
        end
        tick();
        check("e5_valid", int'(vld), 0);
        check("e5_done", int'(done), 1);
        check("e5_busy", int'(busy), 0);
        tick();
        check("e6_done", int'(done), 0);

        exp_q = '{15, 16, 1, 2};
        drain(4'd14, 5'd4, 0, -1, "wrap16");

        exp_q = '{1, 2, 3, 4};
        drain(4'd0, 5'd4, 1, -1, "bp");

        // count=0 start: done after E1, never busy, no word.
        base  = 4'd5;
        count = 5'd0;
        set_start(1'b1);
        tick();
        set_start(1'b0);
        check("z0_busy", int'(busy), 0);
        check("z0_valid", int'(vld), 0);
        check("z0_done", int'(done), 0);
        tick();
        check("z1_done", int'(done), 1);
        check("z1_valid", int'(vld), 0);
        check("z1_busy", int'(busy), 0);
        tick();
        check("z2_done", int'(done), 0);

        exp_q = '{3, 4, 5, 6, 7};
        drain(4'd2, 5'd5, 0, 2, "ignore");

        exp_q = '{6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 16, 1, 2, 3, 4, 5};
        drain(4'd5, 5'd20, 0, -1, "clamp");

        // Async reset in the middle of a drain.
        base  = 4'd0;
        count = 5'd8;
        set_start(1'b1);
        tick();
        set_start(1'b0);
        tick();
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("mrst_valid", int'(vld), 0);
        check("mrst_data", int'(data), 0);
        check("mrst_last", int'(last), 0);
        check("mrst_busy", int'(busy), 0);
        check("mrst_raddr", int'(raddr), 0);
        check("mrst_done", int'(done), 0);
        tick();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("mrst_nodone", int'(done), 0);
        end
        exp_q = '{4, 5};
        drain(4'd3, 5'd2, 0, -1, "after_rst");

        sel = 1'b1;
        exp_q = '{110, 111, 100};
        drain(4'd10, 5'd3, 0, -1, "wrap12");
        exp_q = '{100, 101};
        drain(4'd13, 5'd2, 0, -1, "base12");
        sel = 1'b0;

        mem16[0] = 16'hfffb;
        mem16[1] = 16'd7;
        mem16[2] = 16'h8000;
        mem16[3] = 16'd0;
`ifdef PSUM_DRAIN_RELU_EN
        exp_q = '{0, 7, 0, 0};
`else
        exp_q = '{-5, 7, -32768, 0};
`endif
        drain(4'd0, 5'd4, 0, -1, "relu");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
